// File: rtl/cnt_pkg.sv
// Shared counter definitions: default width and the per-edge operation decode.
// Decode priority: load, then enabled count.
package cnt_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } cnt_op_e;

  // Reset is not decoded here; it overrides everything in the register process.
  function automatic cnt_op_e cnt_decode(input logic load, input logic en, input logic up);
    cnt_op_e op;
    op = OP_HOLD;
    if (load)
      op = OP_LOAD;
    else if (en)
      op = up ? OP_UP : OP_DOWN;
    return op;
  endfunction

endpackage

// File: rtl/cnt.sv
// Loadable up/down binary counter with synchronous active-high reset.
// The count output comes straight from the state register.
import cnt_pkg::*;

module cnt #(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  cnt_op_e          op;

  // Arithmetic wraps naturally modulo 2^WIDTH; there is no saturation.
  always_comb begin
    count_next = count_reg;
    op         = cnt_decode(load, en, up);
    unique case (op)
      OP_LOAD: count_next = count_in;
      OP_UP:   count_next = count_reg + WIDTH'(1);
      OP_DOWN: count_next = count_reg - WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: tb/tb_cnt.sv
// Scoreboard bench for cnt: each cycle pushes the modelled next count and
// compares it against the DUT output just after the following rising edge.
module tb_cnt;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] count_in;
  logic [W-1:0] count;

  int total;
  int bad;
  int txn;

  logic [W-1:0] model_count;
  logic [W-1:0] exp_q[$];

  cnt #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .count_in (count_in),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: count=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic r,
                                               input logic l, input logic e, input logic u,
                                               input logic [W-1:0] ci);
    if (r) return '0;
    if (l) return ci;
    if (e && u) return (cur == {W{1'b1}}) ? '0 : cur + W'(1);
    if (e) return (cur == '0) ? {W{1'b1}} : cur - W'(1);
    return cur;
  endfunction

  // Drive one cycle of stimulus, push the expectation, then compare after the edge.
  task automatic drive_cycle(input string tag, input logic r, input logic l,
                             input logic e, input logic u, input logic [W-1:0] ci);
    logic [W-1:0] exp;
    rst      = r;
    load     = l;
    en       = e;
    up       = u;
    count_in = ci;
    model_count = model_next(model_count, r, l, e, u, ci);
    exp_q.push_back(model_count);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    txn++;
    $display("txn %0d %s rst=%0b load=%0b en=%0b up=%0b in=%0h count=%0h exp=%0h",
             txn, tag, r, l, e, u, ci, count, exp);
    check_val(tag, count, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    txn   = 0;
    model_count = '0;
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; count_in = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) drive_cycle("reset", 1'b1, 1'b0, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 16; i++) drive_cycle("up_wrap", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);

    drive_cycle("load2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 4; i++) drive_cycle("down_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    drive_cycle("load7", 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 5; i++) drive_cycle("hold", 1'b0, 1'b0, 1'b0, logic'(i[0]), 4'h3);

    drive_cycle("load3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    drive_cycle("load_pri", 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    drive_cycle("after_load", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    drive_cycle("load12", 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    drive_cycle("rst_pri", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    drive_cycle("resume", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    for (int i = 0; i < 40; i++) begin
      logic r;
      r = ($urandom_range(0, 15) == 0);
      drive_cycle("random", r, logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
